sound_rd_arbiter: RTL

Read-side controller for the 512×16 sound buffer filled by the serial sound receiver. It owns the buffer's single read port and shares it between two requesters: a playback fetcher that pulls one word per sample tick in FIFO order, and a random-access host readback port. It tracks buffer occupancy from the receiver's `bytes_written`, flags underrun and overrun, and restarts with the receiver on every frame pulse.

---
 rtl/sound_rd_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sound_rd_arbiter.sv
// Read-port arbiter for the 512x16 sound buffer: FIFO playback fetch with priority over host readback.
// Optional build macro SOUND_RD_HOLD_LAST_EN: underrun repeats the last sample instead of zero.
module sound_rd_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rst,
  input  logic [13:0] bytes_written,
  output logic [8:0]  rdaddress,
  input  logic [15:0] q,
  input  logic        sample_tick,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        underrun,
  output logic        overrun,
  input  logic        host_req,
  input  logic [8:0]  host_addr,
  output logic        host_ack,
  output logic [15:0] host_data
);

  localparam int unsigned WAIT_W = 2;
  localparam int unsigned CNT_W  = 13;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {IDLE, PB_RD, HOST_RD} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    rd_count_q, rd_count_d;
  logic                tick_pend_q, tick_pend_d;
  logic [ADDR_W-1:0]   rdaddress_q, rdaddress_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;
  logic                host_ack_q, host_ack_d;
  logic [DATA_W-1:0]   host_data_q, host_data_d;

  logic [CNT_W-1:0]    words_avail_c;
  logic [CNT_W-1:0]    lag_c;
  logic                tick_c;
  logic                wait_done_c;
  logic                unused_c;

  // Only complete 16-bit words are readable; the odd byte is ignored
  assign words_avail_c = bytes_written[13:1];
  assign unused_c      = bytes_written[0];
  assign lag_c         = words_avail_c - rd_count_q;
  assign tick_c        = tick_pend_q | sample_tick;
  assign wait_done_c   = (wait_q == WAIT_W'(RD_LAT));

  // State register and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      wait_q         <= '0;
      rd_count_q     <= '0;
      tick_pend_q    <= 1'b0;
      rdaddress_q    <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
      host_ack_q     <= 1'b0;
      host_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      rd_count_q     <= rd_count_d;
      tick_pend_q    <= tick_pend_d;
      rdaddress_q    <= rdaddress_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
      host_ack_q     <= host_ack_d;
      host_data_q    <= host_data_d;
    end
  end

  // Next-state logic; frame restart wins over everything
  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_c) begin
            if (lag_c != '0) state_d = PB_RD;
          end else if (host_req) begin
            state_d = HOST_RD;
          end
        end
        PB_RD, HOST_RD: if (wait_done_c) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    wait_d         = '0;
    rd_count_d     = rd_count_q;
    tick_pend_d    = tick_pend_q | sample_tick;
    rdaddress_d    = rdaddress_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    underrun_d     = 1'b0;
    overrun_d      = overrun_q | (lag_c > CNT_W'(512));
    host_ack_d     = 1'b0;
    host_data_d    = host_data_q;
    if (rst) begin
      rd_count_d  = '0;
      tick_pend_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_c) begin
            if (lag_c != '0) begin
              rdaddress_d = rd_count_q[ADDR_W-1:0];
            end else begin
              underrun_d     = 1'b1;
              sample_valid_d = 1'b1;
              tick_pend_d    = 1'b0;
`ifndef SOUND_RD_HOLD_LAST_EN
              sample_d       = '0;
`endif
            end
          end else if (host_req) begin
            rdaddress_d = host_addr;
          end
        end
        PB_RD: begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_done_c) begin
            wait_d         = '0;
            sample_d       = q;
            sample_valid_d = 1'b1;
            rd_count_d     = rd_count_q + CNT_W'(1);
            tick_pend_d    = 1'b0;
          end
        end
        HOST_RD: begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_done_c) begin
            wait_d      = '0;
            host_data_d = q;
            host_ack_d  = 1'b1;
          end
        end
        default: wait_d = '0;
      endcase
    end
  end

  assign rdaddress    = rdaddress_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;
  assign host_ack     = host_ack_q;
  assign host_data    = host_data_q;

endmodule
